// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: per-stage valid bits, load-use stall, branch squash,
// external memory stall, optional performance counters (PIPE_PERF_CNT_EN).
// Ports: clk, arst (async, active-high), enable, ext_stall, id_rs, id_rt,
//   id_uses_rt, ex_mem_read, ex_rd, br_taken -> pc_en, stage_en,
//   stage_valid, bubble_ex, retire, instr_cnt, stall_cnt, flush_cnt.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int BR_STAGE   = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic                  ext_stall,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  br_taken,
  output logic                  pc_en,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  bubble_ex,
  output logic                  retire,
  output logic [CNT_W-1:0]      instr_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int N = NUM_STAGES;

  logic [N-1:0] valid_q;
  logic [N-1:0] valid_d;
  logic         freeze;
  logic         flush;
  logic         ld_use;
  logic         hazard;
  logic [N-1:0] shifted;
  logic [N-1:0] keep_mask;

  assign stage_valid = valid_q;

  always_comb begin
    freeze  = ~enable | ext_stall;
    flush   = ~freeze & br_taken & valid_q[BR_STAGE];
    ld_use  = valid_q[1] & valid_q[2] & ex_mem_read
            & (ex_rd != '0)
            & ((ex_rd == id_rs)
               | (id_uses_rt & (ex_rd == id_rt)));
    hazard  = ~freeze & ~flush & ld_use;
    shifted = {valid_q[N-2:0], 1'b1};
    // Stages 0..BR_STAGE hold wrong-path work after a taken branch.
    keep_mask = {N{1'b1}} << (BR_STAGE + 1);

    pc_en     = 1'b1;
    stage_en  = '1;
    bubble_ex = 1'b0;
    valid_d   = shifted;
    retire    = valid_q[N-1] & ~freeze;

    unique case (1'b1)
      freeze: begin
        pc_en    = 1'b0;
        stage_en = '0;
        valid_d  = valid_q;
      end
      flush: begin
        valid_d = shifted & keep_mask;
      end
      hazard: begin
        pc_en       = 1'b0;
        stage_en[0] = 1'b0;
        stage_en[1] = 1'b0;
        bubble_ex   = 1'b1;
        valid_d     = {valid_q[N-2:2], 1'b0, valid_q[1:0]};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

`ifdef PIPE_PERF_CNT_EN
  logic             stall_inc;
  logic             flush_inc;
  logic [CNT_W-1:0] instr_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign stall_inc = enable & (ext_stall | hazard);
  assign flush_inc = flush;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      instr_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (retire && instr_q != '1)
        instr_q <= instr_q + 1'b1;
      if (stall_inc && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (flush_inc && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign instr_cnt = instr_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign instr_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: occupancy model of the pipeline plus
// directed scenarios and randomized traffic with reset pulses.
module tb_pipe_hazard_ctrl;

  localparam int NS = 5;
  localparam int BR = 3;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          arst;
  logic          enable;
  logic          ext_stall;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rt;
  logic          ex_mem_read;
  logic [AW-1:0] ex_rd;
  logic          br_taken;
  logic          pc_en;
  logic [NS-1:0] stage_en;
  logic [NS-1:0] stage_valid;
  logic          bubble_ex;
  logic          retire;
  logic [CW-1:0] instr_cnt;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  pipe_hazard_ctrl #(
    .NUM_STAGES(NS), .BR_STAGE(BR),
    .REG_ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .arst(arst),
    .enable(enable), .ext_stall(ext_stall),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .br_taken(br_taken),
    .pc_en(pc_en), .stage_en(stage_en),
    .stage_valid(stage_valid),
    .bubble_ex(bubble_ex), .retire(retire),
    .instr_cnt(instr_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Model: which pipeline slots hold a real instruction, and event tallies.
  int occ[NS];
  int m_instr, m_stall, m_flush;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string nm,
                     input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int occ_bits();
    int v = 0;
    for (int i = 0; i < NS; i++)
      if (occ[i] != 0) v += (1 << i);
    return v;
  endfunction

  function automatic int cnt_view(input int c);
    if (!PERF) return 0;
    return (c > CMAX) ? CMAX : c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) occ[i] = 0;
    m_instr = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // One clock: drive at negedge, check outputs 1ns later, advance the
  // model across the rising edge, return at the next negedge.
  task automatic cyc(input bit e, input bit xs,
                     input int rs, input int rt,
                     input bit ur, input bit mr,
                     input int rd, input bit bt);
    bit stop, squash, lu;
    int e_pc, e_en, e_bub, e_ret;
    int nxt[NS];
    enable      = e;
    ext_stall   = xs;
    id_rs       = AW'(rs);
    id_rt       = AW'(rt);
    id_uses_rt  = ur;
    ex_mem_read = mr;
    ex_rd       = AW'(rd);
    br_taken    = bt;
    #1;
    stop   = !e || xs;
    squash = !stop && bt && occ[BR] != 0;
    lu     = !stop && !squash
             && occ[1] != 0 && occ[2] != 0 && mr
             && rd != 0
             && (rd == rs || (ur && rd == rt));
    e_pc  = (stop || lu) ? 0 : 1;
    e_en  = stop ? 0 : (lu ? 28 : 31);
    e_bub = lu ? 1 : 0;
    e_ret = (!stop && occ[NS-1] != 0) ? 1 : 0;
    chk("pc_en", pc_en, e_pc);
    chk("stage_en", stage_en, e_en);
    chk("bubble_ex", bubble_ex, e_bub);
    chk("retire", retire, e_ret);
    chk("stage_valid", stage_valid, occ_bits());
    chk("instr_cnt", instr_cnt, cnt_view(m_instr));
    chk("stall_cnt", stall_cnt, cnt_view(m_stall));
    chk("flush_cnt", flush_cnt, cnt_view(m_flush));
    for (int i = 0; i < NS; i++) nxt[i] = occ[i];
    if (!stop) begin
      // Instructions slide one slot down the pipe; IF always fetches.
      for (int i = NS - 1; i > 0; i--) nxt[i] = occ[i-1];
      nxt[0] = 1;
      if (squash)
        for (int i = 0; i <= BR; i++) nxt[i] = 0;
      if (lu) begin
        nxt[0] = occ[0];
        nxt[1] = occ[1];
        nxt[2] = 0;
      end
    end
    if (e_ret != 0) m_instr++;
    if (e && (xs || lu)) m_stall++;
    if (squash) m_flush++;
    @(posedge clk);
    for (int i = 0; i < NS; i++) occ[i] = nxt[i];
    @(negedge clk);
  endtask

  task automatic run_plain(input int n);
    for (int k = 0; k < n; k++)
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    arst = 1'b1;
    #2;
    model_clear();
    chk("rst_valid", stage_valid, 0);
    chk("rst_instr", instr_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    int fill[5];
    fill[0] = 1; fill[1] = 3; fill[2] = 7;
    fill[3] = 15; fill[4] = 31;
    arst = 1'b1;
    enable = 1'b0; ext_stall = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; br_taken = 1'b0;
    model_clear();
    @(negedge clk);
    pulse_reset();

    // Fill: valid grows 1,3,7,15,31.
    for (int k = 0; k < 5; k++) begin
      run_plain(1);
      chk("fill_lit", stage_valid, fill[k]);
    end
    run_plain(6);
    chk("instr_after_fill", instr_cnt, PERF ? 6 : 0);

    // Load-use on rs: one stall cycle, then gone.
    cyc(1, 0, 2, 4, 1, 1, 2, 0);
    chk("hz_valid_lit", stage_valid, 27);
    chk("hz_stall_lit", stall_cnt, PERF ? 1 : 0);
    cyc(1, 0, 2, 4, 1, 1, 2, 0);
    run_plain(3);
    // Load to r0 never stalls; rt ignored when unused.
    cyc(1, 0, 0, 0, 1, 1, 0, 0);
    cyc(1, 0, 7, 9, 0, 1, 9, 0);
    cyc(1, 0, 7, 9, 1, 1, 9, 0);

    // Taken branch with a simultaneous load-use: flush wins.
    run_plain(3);
    cyc(1, 0, 2, 0, 0, 1, 2, 1);
    chk("flush_valid_lit", stage_valid & 15, 0);
    chk("flush_lit", flush_cnt, PERF ? 1 : 0);
    run_plain(6);

    // ext_stall then enable=0, three cycles each.
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    run_plain(2);

    // Randomized traffic with occasional async reset pulses.
    for (int k = 0; k < 3000; k++) begin
      bit e, xs, ur, mr, bt;
      int rs, rt, rd;
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #3;
        pulse_reset();
      end
      e  = ($urandom_range(0, 9) != 0);
      xs = ($urandom_range(0, 7) == 0);
      ur = $urandom_range(0, 1);
      mr = ($urandom_range(0, 2) == 0);
      bt = ($urandom_range(0, 5) == 0);
      rs = $urandom_range(0, 3);
      rt = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      cyc(e, xs, rs, rt, ur, mr, rd, bt);
    end

    run_plain(20);
    chk("sat_instr_lit", instr_cnt, PERF ? 15 : 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
